branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch predictor for the five-stage pipeline: a direct-mapped branch target buffer (BTB) plus a table of saturating counters (the pattern history table, PHT), selectable as bimodal or gshare. Fetch gets a combinational predicted next-PC in the same cycle as the instruction address. Branches resolved in EX/MEM write back outcome and target one cycle later. Built-in counters track resolved branches and mispredicts for performance runs.

## Interface
Parameters:
- ENTRIES, 64, BTB and PHT depth; power of two, 4..1024; IDX = log2(ENTRIES)
- CTR_BITS, 2, PHT counter width, 2..4
- MODE, 0, 0 = bimodal (PHT index = PC[IDX+1:2]), 1 = gshare (PHT index = PC[IDX+1:2] XOR GHR)

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock, all state updates on the rising edge
- RST  in  1  synchronous active-high reset
- lookup_pc  in  32  fetch PC
- pred_taken  out  1  predict taken (BTB hit and counter MSB = 1)
- pred_target  out  32  predicted next PC: the BTB target if pred_taken, else lookup_pc + 4
- pred_ctr_idx  out  IDX  PHT index used for this lookup; pipelined by the datapath
- upd_en  in  1  one resolved conditional branch this cycle
- upd_pc  in  32  PC of the resolved branch
- upd_ctr_idx  in  IDX  pred_ctr_idx returned with that branch
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual taken target (pcPlusFour + BrAddr)
- upd_pred_taken  in  1  pred_taken returned with that branch
- upd_pred_target  in  32  pred_target returned with that branch
- stat_branches  out  32  count of resolved branches
- stat_mispredicts  out  32  count of mispredicted branches

## Operation
- Lookup (combinational):
  - idx = lookup_pc[IDX+1:2]; tag = lookup_pc[31:IDX+2].
  - hit = valid[idx] and tag_mem[idx] == tag.
  - pred_taken = hit and pht[pred_ctr_idx][CTR_BITS-1].
- Update (registered, when upd_en = 1 and RST = 0):
  - PHT at upd_ctr_idx saturates: +1 if taken (max 2^CTR_BITS-1), -1 if not taken (min 0).
  - BTB at upd_pc index:
    - If tag matches, and upd_taken = 1, write target.
    - If tag misses and upd_taken = 1, allocate: write valid, tag and target.
    - In MODE 0 an allocation instead sets the counter to 2^(CTR_BITS-1) (weakly taken), overriding the increment.
    - If tag misses and upd_taken = 0, the BTB is not touched.
  - GHR (IDX bits, MODE 1 only) <= {GHR[IDX-2:0], upd_taken}. GHR is non-speculative. Lookups use the current GHR; updates use the returned index.
  - stat_branches += 1. stat_mispredicts += 1 when:
    - upd_pred_taken != upd_taken, or
    - both are 1 and upd_pred_target != upd_target.
  - Both counters wrap modulo 2^32.
- upd_en = 0: no state change.

## Timing
- Lookup latency 0 cycles. An update becomes visible to a lookup on the cycle after the edge that writes it. There is no write-to-read bypass: a lookup to the same index in the update cycle returns the old contents.
- Reset, sampled at the rising edge with RST = 1:
  - all valid bits cleared; every PHT counter set to 2^(CTR_BITS-1)-1 (weakly not-taken); GHR = 0; stat counters = 0.
  - upd_en is ignored in that cycle.
- Outputs right after reset: pred_taken = 0 and pred_target = lookup_pc + 4 for every PC. pred_ctr_idx = lookup_pc[IDX+1:2], since GHR = 0.
- Reset in the middle of operation discards all learned state. In-flight updates returned after reset deasserts are applied normally.
- Aliasing: distinct PCs with equal idx evict each other; last allocation wins.
- lookup_pc + 4 wraps modulo 2^32.

## Structure
- Place bp_idx_t and bp_ctr_t (parametric widths through package localparams) in shared package bp_types_pkg. Import cpu_types_pkg for word_t.
- One sub-module, bp_pht: holds the counter array and implements the saturating read/update. Parameterised by ENTRIES and CTR_BITS.
- The BTB arrays, GHR and statistics counters live in branch_predictor.

## Test plan
- Reset, then look up 0x00000040 → pred_taken = 0, pred_target = 0x00000044, both stats = 0.
- MODE 0, CTR_BITS 2. Update upd_pc 0x40, taken, target 0x100 → next cycle lookup 0x40 gives pred_taken = 1, target 0x100, stat_mispredicts = 1.
- Same entry, then three not-taken updates → counter steps 2→1→0→0 (saturates). Lookup predicts not-taken after the first update.
- ENTRIES 64: allocate 0x40, then 0x140 (same idx, different tag) → lookup 0x40 misses, lookup 0x140 hits with its target.
- MODE 1: drive taken, not-taken, taken on one PC → GHR = 0b101. pred_ctr_idx = PC index XOR 5 for that lookup.
- Update and lookup the same index in the same cycle → the lookup returns the old value. Asserting RST with upd_en = 1 → all state cleared, and the update is dropped.

Source files
------------

// File: rtl/bp_types_pkg.sv
// Branch predictor types; the default table geometry feeds the index and counter widths.
package bp_types_pkg;
  localparam int BP_ENTRIES  = 64;
  localparam int BP_CTR_BITS = 2;
  localparam int BP_IDX      = $clog2(BP_ENTRIES);

  typedef logic [BP_IDX-1:0]      bp_idx_t;
  typedef logic [BP_CTR_BITS-1:0] bp_ctr_t;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_e;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types used across the pipeline.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/bp_pht.sv
// Pattern history table: saturating counters with a combinational direction read.
module bp_pht
  import bp_types_pkg::*;
#(
  parameter int  ENTRIES  = BP_ENTRIES,
  parameter int  CTR_BITS = BP_CTR_BITS,
  localparam int IDX      = $clog2(ENTRIES)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [IDX-1:0] rd_idx,
  output logic           rd_taken,
  input  logic           upd_en,
  input  logic [IDX-1:0] upd_idx,
  input  logic           upd_taken,
  input  logic           upd_alloc
);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_MIN = '0;
  localparam logic [CTR_BITS-1:0] WEAK_T  = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] upd_cur;

  assign rd_taken = ctr_q[rd_idx][CTR_BITS-1];
  assign upd_cur  = ctr_q[upd_idx];

  // A fresh BTB allocation restarts the counter at weakly taken instead of stepping it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WEAK_NT;
    end else if (upd_en) begin
      if (upd_alloc) begin
        ctr_q[upd_idx] <= WEAK_T;
      end else if (upd_taken) begin
        if (upd_cur != CTR_MAX) ctr_q[upd_idx] <= upd_cur + 1'b1;
      end else begin
        if (upd_cur != CTR_MIN) ctr_q[upd_idx] <= upd_cur - 1'b1;
      end
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus bimodal/gshare PHT with same-cycle next-PC prediction and stats.
module branch_predictor
  import cpu_types_pkg::*;
  import bp_types_pkg::*;
#(
  parameter int  ENTRIES  = BP_ENTRIES,
  parameter int  CTR_BITS = BP_CTR_BITS,
  parameter int  MODE     = 0,
  localparam int IDX      = $clog2(ENTRIES)
) (
  input  logic           CLK,
  input  logic           RST,
  input  word_t          lookup_pc,
  output logic           pred_taken,
  output word_t          pred_target,
  output logic [IDX-1:0] pred_ctr_idx,
  input  logic           upd_en,
  input  word_t          upd_pc,
  input  logic [IDX-1:0] upd_ctr_idx,
  input  logic           upd_taken,
  input  word_t          upd_target,
  input  logic           upd_pred_taken,
  input  word_t          upd_pred_target,
  output word_t          stat_branches,
  output word_t          stat_mispredicts
);
  localparam int TAG_W = 32 - IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  word_t              target_mem [ENTRIES];
  logic [IDX-1:0]     ghr_q;

  logic [IDX-1:0]     lk_idx;
  logic [IDX-1:0]     up_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic [TAG_W-1:0]   up_tag;
  logic               lk_hit;
  logic               up_hit;
  logic               pht_taken;
  logic               alloc;
  logic               mispredict;
  logic               unused_pc_bits;

  assign lk_idx = lookup_pc[IDX+1:2];
  assign lk_tag = lookup_pc[31:IDX+2];
  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[31:IDX+2];
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_hit = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_mem[up_idx] == up_tag);

  assign pred_ctr_idx = lk_idx ^ ghr_q;
  assign pred_taken   = lk_hit & pht_taken;
  assign pred_target  = pred_taken ? target_mem[lk_idx] : lookup_pc + 32'd4;

  assign alloc      = upd_en & upd_taken & ~up_hit;
  assign mispredict = (upd_pred_taken != upd_taken) ||
                      (upd_pred_taken && upd_taken && (upd_pred_target != upd_target));

  bp_pht #(
    .ENTRIES  (ENTRIES),
    .CTR_BITS (CTR_BITS)
  ) u_pht (
    .CLK       (CLK),
    .RST       (RST),
    .rd_idx    (pred_ctr_idx),
    .rd_taken  (pht_taken),
    .upd_en    (upd_en),
    .upd_idx   (upd_ctr_idx),
    .upd_taken (upd_taken),
    .upd_alloc (alloc & (MODE == int'(BP_BIMODAL)))
  );

  // History is only kept in gshare; bimodal sees a constant zero so the XOR is a no-op.
  generate
    if (MODE == int'(BP_GSHARE)) begin : g_ghr
      always_ff @(posedge CLK) begin
        if (RST) ghr_q <= '0;
        else if (upd_en) ghr_q <= {ghr_q[IDX-2:0], upd_taken};
      end
    end else begin : g_no_ghr
      assign ghr_q = '0;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q          <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd_en) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
      if (upd_taken) valid_q[up_idx] <= 1'b1;
    end
  end

  // Taken branches write tag and target whether they hit or allocate; valid gates stale data.
  always_ff @(posedge CLK) begin
    if (!RST && upd_en && upd_taken) begin
      tag_mem[up_idx]    <= up_tag;
      target_mem[up_idx] <= upd_target;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: bimodal and gshare instances share stimulus, checked against a table model.
module tb_branch_predictor;
  import bp_types_pkg::*;

  localparam int N      = BP_ENTRIES;
  localparam int HALF   = 2 ** (BP_CTR_BITS - 1);
  localparam int CTRMAX = 2 ** BP_CTR_BITS - 1;

  typedef struct {
    string       lbl;
    logic        tk0;
    logic [31:0] tg0;
    logic [31:0] ix0;
    logic        tk1;
    logic [31:0] tg1;
    logic [31:0] ix1;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] lookup_pc;
  logic        upd_en;
  logic [31:0] upd_pc;
  bp_idx_t     upd_ctr_idx;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  logic        p0_taken, p1_taken;
  logic [31:0] p0_target, p1_target;
  bp_idx_t     p0_idx, p1_idx;
  logic [31:0] s0_br, s0_mp, s1_br, s1_mp;

  int checks   = 0;
  int failures = 0;

  exp_t sb[$];
  exp_t mon_e;

  bit          mv   [N];
  logic [31:0] mtag [N];
  logic [31:0] mtgt [N];
  int          mpht [2][N];
  int          mghr;
  logic [31:0] mbr, mmp;

  always #5 CLK = ~CLK;

  branch_predictor #(.ENTRIES(N), .CTR_BITS(BP_CTR_BITS), .MODE(0)) dut0 (
    .CLK(CLK), .RST(RST), .lookup_pc(lookup_pc),
    .pred_taken(p0_taken), .pred_target(p0_target), .pred_ctr_idx(p0_idx),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_ctr_idx(upd_ctr_idx), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .stat_branches(s0_br), .stat_mispredicts(s0_mp)
  );

  branch_predictor #(.ENTRIES(N), .CTR_BITS(BP_CTR_BITS), .MODE(1)) dut1 (
    .CLK(CLK), .RST(RST), .lookup_pc(lookup_pc),
    .pred_taken(p1_taken), .pred_target(p1_target), .pred_ctr_idx(p1_idx),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_ctr_idx(upd_ctr_idx), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .stat_branches(s1_br), .stat_mispredicts(s1_mp)
  );

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0;
      mpht[0][i] = HALF - 1;
      mpht[1][i] = HALF - 1;
    end
    mghr = 0;
    mbr  = 32'd0;
    mmp  = 32'd0;
  endtask

  task automatic chk(input string name, input string lbl, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s (%s): got %h expected %h", name, lbl, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    chk("bimodal pred_taken",   e.lbl, 32'(p0_taken),  32'(e.tk0));
    chk("bimodal pred_target",  e.lbl, p0_target,      e.tg0);
    chk("bimodal pred_ctr_idx", e.lbl, 32'(p0_idx),    e.ix0);
    chk("bimodal stat_branches",    e.lbl, s0_br, e.br);
    chk("bimodal stat_mispredicts", e.lbl, s0_mp, e.mp);
    chk("gshare pred_taken",    e.lbl, 32'(p1_taken),  32'(e.tk1));
    chk("gshare pred_target",   e.lbl, p1_target,      e.tg1);
    chk("gshare pred_ctr_idx",  e.lbl, 32'(p1_idx),    e.ix1);
    chk("gshare stat_branches",     e.lbl, s1_br, e.br);
    chk("gshare stat_mispredicts",  e.lbl, s1_mp, e.mp);
  endtask

  // One cycle: drive inputs, predict the lookup from the pre-edge model, then fold in the edge.
  task automatic applyStimulus(input logic rst, input logic [31:0] lpc, input logic ue,
                               input logic [31:0] upc, input int cidx, input logic tk,
                               input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                               input string lbl);
    exp_t        e;
    int          li, ui, ci;
    logic [31:0] ltag, utag;
    bit          hit, uhit, pt;
    @(posedge CLK);
    #1;
    RST = rst; lookup_pc = lpc; upd_en = ue; upd_pc = upc;
    upd_ctr_idx = bp_idx_t'(cidx); upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;

    li   = int'(lpc >> 2) % N;
    ltag = lpc / (32'd4 * 32'(N));
    hit  = mv[li] && (mtag[li] == ltag);
    e.lbl = lbl;
    pt = hit && (mpht[0][li] >= HALF);
    e.tk0 = pt; e.tg0 = pt ? mtgt[li] : lpc + 32'd4; e.ix0 = 32'(li);
    ci = li ^ mghr;
    pt = hit && (mpht[1][ci] >= HALF);
    e.tk1 = pt; e.tg1 = pt ? mtgt[li] : lpc + 32'd4; e.ix1 = 32'(ci);
    e.br = mbr; e.mp = mmp;
    sb.push_back(e);

    if (rst) begin
      modelReset();
    end else if (ue) begin
      ui   = int'(upc >> 2) % N;
      utag = upc / (32'd4 * 32'(N));
      uhit = mv[ui] && (mtag[ui] == utag);
      for (int m = 0; m < 2; m++) begin
        if (m == 0 && tk && !uhit) mpht[m][cidx] = HALF;
        else if (tk) mpht[m][cidx] = (mpht[m][cidx] < CTRMAX) ? mpht[m][cidx] + 1 : CTRMAX;
        else mpht[m][cidx] = (mpht[m][cidx] > 0) ? mpht[m][cidx] - 1 : 0;
      end
      if (tk) begin
        mv[ui] = 1'b1; mtag[ui] = utag; mtgt[ui] = tgt;
      end
      mghr = ((mghr << 1) | int'(tk)) % N;
      mbr  = mbr + 32'd1;
      if ((ptk != tk) || (ptk && tk && ptgt != tgt)) mmp = mmp + 32'd1;
    end
  endtask

  function automatic logic [31:0] pickPc();
    logic [31:0] r;
    if ($urandom_range(0, 19) == 0) begin
      r = $urandom;
      return {r[31:2], 2'b00};
    end
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checkOutput(mon_e);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] upc, tgt, pt;
    int          cidx;
    RST = 1'b1; lookup_pc = '0; upd_en = 1'b0; upd_pc = '0; upd_ctr_idx = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    repeat (2) @(posedge CLK);
    modelReset();

    applyStimulus(0, 32'h40, 0, 0, 0, 0, 0, 0, 0, "after reset");
    applyStimulus(0, 32'h40, 1, 32'h40, 16, 1, 32'h100, 0, 32'h44, "alloc same-cycle lookup");
    applyStimulus(0, 32'h40, 0, 0, 0, 0, 0, 0, 0, "alloc visible");
    applyStimulus(0, 32'h40, 1, 32'h40, 16, 0, 32'h100, 1, 32'h100, "not-taken 1");
    applyStimulus(0, 32'h40, 1, 32'h40, 16, 0, 32'h100, 0, 32'h44, "not-taken 2");
    applyStimulus(0, 32'h40, 1, 32'h40, 16, 0, 32'h100, 0, 32'h44, "not-taken 3");
    applyStimulus(0, 32'h40, 1, 32'h140, 16, 1, 32'h200, 0, 32'h144, "alias alloc");
    applyStimulus(0, 32'h40, 0, 0, 0, 0, 0, 0, 0, "evicted pc misses");
    applyStimulus(0, 32'h140, 0, 0, 0, 0, 0, 0, 0, "alias pc hits");
    applyStimulus(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, "pc+4 wraps");
    applyStimulus(1, 32'h80, 1, 32'h80, 32, 1, 32'h300, 0, 32'h84, "reset drops update");
    applyStimulus(0, 32'h80, 0, 0, 0, 0, 0, 0, 0, "state cleared");
    applyStimulus(0, 32'h80, 1, 32'h80, 32, 1, 32'h300, 0, 32'h84, "ghr taken");
    applyStimulus(0, 32'h80, 1, 32'h80, 32, 0, 32'h300, 0, 32'h84, "ghr not-taken");
    applyStimulus(0, 32'h80, 1, 32'h80, 32, 1, 32'h300, 1, 32'h300, "ghr taken again");
    applyStimulus(0, 32'h80, 0, 0, 0, 0, 0, 0, 0, "gshare idx xor 5");

    for (int i = 0; i < 400; i++) begin
      upc  = pickPc();
      tgt  = $urandom;
      tgt  = {tgt[31:2], 2'b00};
      cidx = ($urandom_range(0, 1) == 0) ? (int'(upc >> 2) % N) : int'($urandom_range(0, N - 1));
      pt   = ($urandom_range(0, 1) == 0) ? tgt : upc + 32'd4;
      applyStimulus(($urandom_range(0, 99) == 0), pickPc(), ($urandom_range(0, 3) != 0), upc, cidx,
                    1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)), pt, "random");
    end

    @(negedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
